// File: rtl/bit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_addsub
// Description : Bit-serial adder/subtractor. One full adder is reused over
//               WIDTH clock cycles, processing operands LSB first. Subtraction
//               is performed as A + ~B + 1 by inverting B bits and seeding the
//               carry with sel.
// Ports       : clk    - clock, rising edge active
//               reset  - asynchronous active-high reset
//               start  - operation request, honoured in IDLE or DONE
//               a, b   - operands (WIDTH bits), captured on the accepting edge
//               sel    - 0 = A+B, 1 = A-B, captured on the accepting edge
//               busy   - high while bits are being processed
//               done   - one-cycle pulse, result/cout/ovf valid
//               result - sum or difference, modulo 2^WIDTH
//               cout   - final carry-out (for subtraction, 0 means borrow)
//               ovf    - signed overflow flag
// Config      : define SIGNED_OVF_EN to build the signed-overflow logic;
//               without it ovf is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int             c_IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WIDTH - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sel;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;

    logic               w_accept;
    logic               w_last_bit;
    logic               w_bnew;
    logic               w_sum;
    logic               w_carry_next;

    // start is only honoured when no operation is in flight
    assign w_accept   = start && ((r_state == c_S_IDLE) || (r_state == c_S_DONE));
    assign w_last_bit = (r_idx == c_LAST_IDX);

    // Operand registers shift right each RUN cycle, so bit 0 is always the
    // bit currently being processed.
    assign w_bnew       = r_b[0] ^ r_sel;
    assign w_sum        = r_a[0] ^ w_bnew ^ r_carry;
    assign w_carry_next = (r_a[0] & w_bnew) | (r_carry & (r_a[0] ^ w_bnew));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: if (start)      w_next_state = c_S_RUN;
            c_S_RUN:  if (w_last_bit) w_next_state = c_S_DONE;
            c_S_DONE: w_next_state = start ? c_S_RUN : c_S_IDLE;
            default:  w_next_state = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
`ifdef SIGNED_OVF_EN
    logic r_msb_carry;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sel       <= 1'b0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_cout      <= 1'b0;
`ifdef SIGNED_OVF_EN
            r_msb_carry <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_sel   <= sel;
            r_idx   <= '0;
            r_carry <= sel;
        end else if (r_state == c_S_RUN) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            // sum bits enter from the MSB side; after WIDTH shifts the
            // first-computed bit has reached bit 0
            r_result <= {w_sum, r_result[WIDTH-1:1]};
            r_carry  <= w_carry_next;
            r_idx    <= r_idx + c_IDX_W'(1);
            if (w_last_bit) begin
                r_cout      <= w_carry_next;
`ifdef SIGNED_OVF_EN
                // carry entering the MSB adder stage
                r_msb_carry <= r_carry;
`endif
            end
        end
    end

    assign busy   = (r_state == c_S_RUN);
    assign done   = (r_state == c_S_DONE);
    assign result = r_result;
    assign cout   = r_cout;

`ifdef SIGNED_OVF_EN
    // Both terms only change on the final RUN edge, so ovf holds with them.
    assign ovf = r_msb_carry ^ r_cout;
`else
    assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serial_addsub
// Description : Self-checking bench for bit_serial_addsub (WIDTH = 8).
//               Directed vector table, randomized operations against an
//               arithmetic reference model, and hand-written sequences for
//               ignored start, back-to-back operation and reset abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serial_addsub;

    localparam int c_W = 8;
`ifdef SIGNED_OVF_EN
    localparam bit c_OVF_EN = 1'b1;
`else
    localparam bit c_OVF_EN = 1'b0;
`endif

    logic           clk;
    logic           reset;
    logic           start;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           sel;
    logic           busy;
    logic           done;
    logic [c_W-1:0] result;
    logic           cout;
    logic           ovf;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sel;
        logic [7:0] res;
        logic       cout;
        logic       ovf;   // value when signed overflow logic is built
    } vec_t;

    vec_t vecs[8];

    bit_serial_addsub #(.WIDTH(c_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .sel    (sel),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain signed/unsigned arithmetic on whole operands.
    function automatic void model(input logic [7:0] xa, input logic [7:0] xb, input logic xs,
                                  output logic [7:0] r, output logic c, output logic o);
        int ua, ub, sa, sb, ures, sres;
        ua = int'(xa);
        ub = int'(xb);
        sa = (xa >= 8'd128) ? ua - 256 : ua;
        sb = (xb >= 8'd128) ? ub - 256 : ub;
        if (!xs) begin
            ures = ua + ub;
            sres = sa + sb;
            c    = (ures >= 256);
        end else begin
            ures = ua - ub + 256;
            sres = sa - sb;
            c    = (ua >= ub);       // no borrow
        end
        r = 8'(ures % 256);
        o = c_OVF_EN && ((sres > 127) || (sres < -128));
    endfunction

    // Waits (bounded) for done; lat counts edges since the last sample point.
    task automatic wait_done(output int lat);
        lat = 0;
        forever begin
            @(posedge clk);
            #1;
            lat++;
            if (done || lat >= 20) break;
        end
    endtask

    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xs,
                          output logic [7:0] r, output logic c, output logic o);
        int lat;
        @(negedge clk);
        a = xa; b = xb; sel = xs; start = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        // operands changing after acceptance must not matter
        a   = 8'($urandom_range(255));
        b   = 8'($urandom_range(255));
        sel = 1'($urandom_range(1));
        wait_done(lat);
        r = result; c = cout; o = ovf;
        chk("latency", lat, 32'd8);
        chk("busy_in_done", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("result_hold", {24'd0, result}, {24'd0, r});
    endtask

    initial begin
        logic [7:0] r, er;
        logic       c, ec, o, eo;
        logic [7:0] xa, xb;
        logic       xs;
        int         lat, dcnt;

        vecs[0] = '{8'd100,  8'd55,   1'b0, 8'd155,  1'b0, 1'b1};
        vecs[1] = '{8'd200,  8'd100,  1'b0, 8'd44,   1'b1, 1'b0};
        vecs[2] = '{8'd5,    8'd7,    1'b1, 8'hFE,   1'b0, 1'b0};
        vecs[3] = '{8'h7F,   8'h01,   1'b0, 8'h80,   1'b0, 1'b1};
        vecs[4] = '{8'h80,   8'h01,   1'b1, 8'h7F,   1'b1, 1'b1};
        vecs[5] = '{8'h00,   8'h00,   1'b1, 8'h00,   1'b1, 1'b0};
        vecs[6] = '{8'hFF,   8'h01,   1'b0, 8'h00,   1'b1, 1'b0};
        vecs[7] = '{8'h80,   8'h80,   1'b0, 8'h00,   1'b1, 1'b1};

        reset = 1'b1; start = 1'b0; a = '0; b = '0; sel = 1'b0;
        #2;
        chk("rst_busy",   {31'd0, busy},   32'd0);
        chk("rst_done",   {31'd0, done},   32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_cout",   {31'd0, cout},   32'd0);
        chk("rst_ovf",    {31'd0, ovf},    32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // directed vector table
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sel, r, c, o);
            chk("vec_result", {24'd0, r}, {24'd0, vecs[i].res});
            chk("vec_cout",   {31'd0, c}, {31'd0, vecs[i].cout});
            chk("vec_ovf",    {31'd0, o}, {31'd0, vecs[i].ovf & c_OVF_EN});
        end

        // randomized operations against the model
        for (int i = 0; i < 30; i++) begin
            xa = 8'($urandom_range(255));
            xb = 8'($urandom_range(255));
            xs = 1'($urandom_range(1));
            model(xa, xb, xs, er, ec, eo);
            run_op(xa, xb, xs, r, c, o);
            chk("rnd_result", {24'd0, r}, {24'd0, er});
            chk("rnd_cout",   {31'd0, c}, {31'd0, ec});
            chk("rnd_ovf",    {31'd0, o}, {31'd0, eo});
        end

        // start pulsed during RUN is ignored
        @(negedge clk);
        a = 8'h3C; b = 8'h15; sel = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        forever begin
            @(negedge clk);
            if (lat == 2) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; sel = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (done || lat >= 20) break;
        end
        model(8'h3C, 8'h15, 1'b1, er, ec, eo);
        chk("ign_latency", lat, 32'd8);
        chk("ign_result", {24'd0, result}, {24'd0, er});
        chk("ign_cout",   {31'd0, cout},   {31'd0, ec});
        @(posedge clk);
        #1;
        chk("ign_no_second_done", {31'd0, done}, 32'd0);

        // back-to-back: start held high through DONE
        @(negedge clk);
        a = 8'd10; b = 8'd20; sel = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(lat);
        chk("b2b_latency1", lat, 32'd8);
        chk("b2b_result1", {24'd0, result}, 32'd30);
        chk("b2b_busy_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        a = 8'h90; b = 8'h30; sel = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_busy_again", {31'd0, busy}, 32'd1);
        chk("b2b_done_drop",  {31'd0, done}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        model(8'h90, 8'h30, 1'b1, er, ec, eo);
        chk("b2b_latency2", lat, 32'd8);
        chk("b2b_result2", {24'd0, result}, {24'd0, er});
        chk("b2b_cout2",   {31'd0, cout},   {31'd0, ec});
        chk("b2b_ovf2",    {31'd0, ovf},    {31'd0, eo});

        // reset in the middle of RUN aborts the operation
        @(negedge clk);
        a = 8'h55; b = 8'h2A; sel = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort_busy",   {31'd0, busy},   32'd0);
        chk("abort_done",   {31'd0, done},   32'd0);
        chk("abort_result", {24'd0, result}, 32'd0);
        chk("abort_cout",   {31'd0, cout},   32'd0);
        chk("abort_ovf",    {31'd0, ovf},    32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        chk("abort_no_done", dcnt, 32'd0);
        model(8'hC8, 8'h4B, 1'b1, er, ec, eo);
        run_op(8'hC8, 8'h4B, 1'b1, r, c, o);
        chk("post_rst_result", {24'd0, r}, {24'd0, er});
        chk("post_rst_cout",   {31'd0, c}, {31'd0, ec});
        chk("post_rst_ovf",    {31'd0, o}, {31'd0, eo});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
